// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a length-prefixed, checksummed byte stream into instruction memory and holds the core in reset until the load succeeds
module imem_boot_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_err
);
  typedef enum logic [2:0] {LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR} state_t;
  state_t state, state_nx;
  logic [7:0]  len_lo, csum, csum_nx;
  logic [15:0] n, n_rx, word_idx;
  logic [1:0]  byte_idx;
  logic [31:0] word, word_nx;
  logic        acc;
  assign rx_ready = rst && (state inside {LEN0, LEN1, DATA, CSUM});
  assign acc      = rx_valid && rx_ready;
  assign n_rx     = {rx_data, len_lo};
  assign csum_nx  = csum + rx_data;
  assign word_nx  = {rx_data, word[31:8]};
  always_comb begin
    state_nx = state;
    case (state)
      LEN0:    state_nx = acc ? LEN1 : LEN0;
      LEN1:    state_nx = !acc ? LEN1 : (n_rx == 16'd0) ? CSUM : (n_rx > 16'(MAX_WORDS)) ? ERR : DATA;
      DATA:    state_nx = (acc && byte_idx == 2'd3) ? WRITE : DATA;
      WRITE:   state_nx = (word_idx == n - 16'd1) ? CSUM : DATA;
      CSUM:    state_nx = !acc ? CSUM : (csum_nx == 8'd0) ? DONE : ERR;
      DONE:    state_nx = reload ? LEN0 : DONE;
      ERR:     state_nx = reload ? LEN0 : ERR;
      default: state_nx = LEN0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= LEN0;
      byte_idx   <= '0;
      word_idx   <= '0;
      csum       <= '0;
      len_lo     <= '0;
      n          <= '0;
      word       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst   <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (acc) csum <= csum_nx;
      if (acc && state == LEN0) len_lo <= rx_data;
      if (acc && state == LEN1) n <= n_rx;
      if (acc && state == DATA) begin
        word     <= word_nx;
        byte_idx <= byte_idx + 2'd1;
      end
      if (state == WRITE) word_idx <= word_idx + 16'd1;
      if ((state == DONE || state == ERR) && reload) begin
        byte_idx <= '0;
        word_idx <= '0;
        csum     <= '0;
      end
      // outputs are decoded from the next state so they line up with the state register
      imem_we <= state_nx == WRITE;
      if (state_nx == WRITE) begin
        imem_addr  <= word_idx[ADDR_W-1:0];
        imem_wdata <= word_nx;
      end
      core_rst  <= state_nx != DONE;
      load_done <= state_nx == DONE;
      load_err  <= state_nx == ERR;
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: random and directed frames against a byte-level frame model, writes checked by a scoreboard monitor
module tb_imem_boot_loader;
  localparam int ADDR_W = 8, MAX_WORDS = 256;
  logic clk = 0, rst = 0, rx_valid = 0, reload = 0;
  logic [7:0] rx_data = 0;
  logic rx_ready, imem_we, core_rst, load_done, load_err;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0] imem_wdata;
  typedef struct packed {logic [ADDR_W-1:0] a; logic [31:0] d;} wr_t;
  wr_t exp_q[$];
  logic [7:0] frame[$];
  int checks = 0, failures = 0, stalls = 0;

  imem_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .load_done(load_done), .load_err(load_err));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (imem_we) begin
      if (exp_q.size() == 0) chk("unexpected_write", 32'(imem_we), 32'd0);
      else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(imem_addr), 32'(e.a));
        chk("write_data", imem_wdata, e.d);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    if (gap) begin
      rx_valid = 0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rx_valid = 1;
    rx_data = b;
    t = 0;
    @(negedge clk);
    while (!rx_ready && t < 20) begin
      stalls++;
      t++;
      @(negedge clk);
    end
    if (!rx_ready) chk("rx_ready_timeout", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic make_frame(input int n, input bit good);
    logic [7:0] s;
    frame.delete();
    frame.push_back(n[7:0]);
    frame.push_back(n[15:8]);
    if (n <= MAX_WORDS)
      for (int i = 0; i < 4 * n; i++) frame.push_back(8'($urandom));
    s = 0;
    foreach (frame[i]) s = s + frame[i];
    s = 8'(0) - s;
    if (!good) s = s + 8'($urandom_range(1, 255));
    frame.push_back(s);
  endtask

  task automatic pulse_reload();
    reload = 1;
    @(posedge clk);
    #1;
    reload = 0;
    chk("reload_rx_ready", 32'(rx_ready), 32'd1);
    chk("reload_done", 32'(load_done), 32'd0);
    chk("reload_err", 32'(load_err), 32'd0);
    chk("reload_core_rst", 32'(core_rst), 32'd1);
  endtask

  task automatic run_frame(input bit b2b);
    int n, nb;
    logic [7:0] s;
    bit ok;
    n = {frame[1], frame[0]};
    if (n > MAX_WORDS) nb = 2;
    else begin
      nb = 4 * n + 3;
      for (int w = 0; w < n; w++)
        exp_q.push_back({ADDR_W'(w), frame[4*w+5], frame[4*w+4], frame[4*w+3], frame[4*w+2]});
    end
    s = 0;
    for (int i = 0; i < nb; i++) s = s + frame[i];
    ok = (n <= MAX_WORDS) && (s == 8'd0);
    stalls = 0;
    for (int i = 0; i < nb; i++) send_byte(frame[i], !b2b);
    rx_valid = 0;
    chk("load_done", 32'(load_done), 32'(ok));
    chk("load_err", 32'(load_err), 32'(!ok));
    chk("core_rst", 32'(core_rst), 32'(!ok));
    chk("end_rx_ready", 32'(rx_ready), 32'd0);
    chk("writes_pending", 32'(exp_q.size()), 32'd0);
    if (b2b && n <= MAX_WORDS) chk("stall_cycles", 32'(stalls), 32'(n));
    repeat (2) @(posedge clk);
    #1;
    chk("hold_done", 32'(load_done), 32'(ok));
    chk("hold_err", 32'(load_err), 32'(!ok));
    pulse_reload();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    rst = 1;
    @(negedge clk);
    chk("idle_rx_ready", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;
    frame = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h47};
    run_frame(0);
    frame = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h48};
    run_frame(0);
    frame = '{8'h00, 8'h00, 8'h00};
    run_frame(0);
    frame = '{8'h2C, 8'h01};
    run_frame(0);
    make_frame(2, 1);
    run_frame(1);
    make_frame(MAX_WORDS + 1, 1);
    run_frame(1);
    make_frame(MAX_WORDS, 1);
    run_frame(1);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h05, 0);
    rx_valid = 0;
    rst = 0;
    @(posedge clk);
    #1;
    chk("mid_rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("mid_rst_core_rst", 32'(core_rst), 32'd1);
    chk("mid_rst_we", 32'(imem_we), 32'd0);
    chk("mid_rst_addr", 32'(imem_addr), 32'd0);
    chk("mid_rst_wdata", imem_wdata, 32'd0);
    chk("mid_rst_done", 32'(load_done), 32'd0);
    chk("mid_rst_err", 32'(load_err), 32'd0);
    rst = 1;
    frame = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h47};
    run_frame(0);
    for (int k = 0; k < 25; k++) begin
      int n;
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(MAX_WORDS + 1, 1000) : $urandom_range(0, 6);
      make_frame(n, $urandom_range(0, 3) != 0);
      run_frame($urandom_range(0, 1) == 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
